// File: rtl/mmu_walk_delay_seq.sv
// MMU table-walk delay sequencer: fixed-priority arm, programmable idle-bus delay, one-cycle walk start.
// Optional abort statistics counter enabled by defining MMU_WALK_DELAY_STATS_EN.
module mmu_walk_delay_seq #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CH_W    = 1,
  parameter int unsigned DELAY_W = 4
) (
  input  logic               CLK,
  input  logic               RESET_CPU,
  input  logic               BUS_BSY,
  input  logic [NUM_CH-1:0]  MMU_RUNTIME_REQ,
  input  logic [NUM_CH-1:0]  MMU_RUNTIME_STALL,
  input  logic [DELAY_W-1:0] DELAY_CYCLES,
  input  logic               WALK_DONE,
  output logic               MMU_WALK_DELAY_ARMED,
  output logic               WALK_GO,
  output logic [CH_W-1:0]    WALK_CH,
  output logic               WALK_ACTIVE,
  output logic [7:0]         ABORT_COUNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WALK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               armed_q, armed_d;
  logic               go_q, go_d;
  logic               active_q, active_d;

  logic [NUM_CH-1:0]  qual;
  logic [CH_W-1:0]    ch_sel;
  logic               abort;

  assign qual = MMU_RUNTIME_REQ & MMU_RUNTIME_STALL;

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    ch_sel = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (qual[i]) ch_sel = CH_W'(i);
    end
  end

  assign abort = BUS_BSY | ~MMU_RUNTIME_REQ[ch_q] | ~MMU_RUNTIME_STALL[ch_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    armed_d  = armed_q;
    go_d     = 1'b0;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (!BUS_BSY && (|qual)) begin
          state_d = ARMED;
          ch_d    = ch_sel;
          cnt_d   = DELAY_CYCLES;
          armed_d = 1'b1;
        end
      end
      ARMED: begin
        // Abort takes precedence over expiry, so a late abort suppresses WALK_GO.
        if (abort) begin
          state_d = IDLE;
          armed_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d  = WALK;
          armed_d  = 1'b0;
          go_d     = 1'b1;
          active_d = 1'b1;
        end
      end
      WALK: begin
        if (WALK_DONE) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        armed_d  = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET_CPU) begin
    if (RESET_CPU) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ch_q     <= '0;
      armed_q  <= 1'b0;
      go_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      armed_q  <= armed_d;
      go_q     <= go_d;
      active_q <= active_d;
    end
  end

  assign MMU_WALK_DELAY_ARMED = armed_q;
  assign WALK_GO              = go_q;
  assign WALK_CH              = ch_q;
  assign WALK_ACTIVE          = active_q;

`ifdef MMU_WALK_DELAY_STATS_EN
  logic [7:0] abort_cnt_q, abort_cnt_d;
  logic       abort_evt;

  assign abort_evt = (state_q == ARMED) && abort;

  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (abort_evt && (abort_cnt_q != 8'hFF)) abort_cnt_d = abort_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or posedge RESET_CPU) begin
    if (RESET_CPU) abort_cnt_q <= 8'd0;
    else           abort_cnt_q <= abort_cnt_d;
  end

  assign ABORT_COUNT = abort_cnt_q;
`else
  assign ABORT_COUNT = 8'd0;
`endif

endmodule
